// File: rtl/sc_frogregister.sv
// sc_frogregister: position register for the frog in a Frogger-style game.
// It holds the frog's row/column and applies one movement command per clock,
// using the priority clear > up > down > left > right. Moves that would leave
// the playfield are refused and reported on Reject. Every output is registered
// and changes together with the position.
//
// Ports:
//   SC_FROGREGISTER_CLOCK_50                 system clock
//   SC_FROGREGISTER_RESET_InHigh             synchronous reset, active high
//   SC_FROGREGISTER_clear_InLow              return frog to start, active low
//   SC_FROGREGISTER_load0_InLow              move up one row, active low
//   SC_FROGREGISTER_load1_InLow              move down one row, active low
//   SC_FROGREGISTER_shiftselection_In        01 left, 10 right, 00/11 hold
//   SC_FROGREGISTER_Matrix_Out               one-hot map, bit r*COLS+c
//   SC_FROGREGISTER_bottomsidecomparator_OutLow  low on bottom row
//   SC_FROGREGISTER_topsidecomparator_OutLow     low on row 0
//   SC_FROGREGISTER_Arrive_OutLow            one-cycle low on entering row 0
//   SC_FROGREGISTER_Ack_OutLow               one-cycle low after a move
//   SC_FROGREGISTER_Reject_OutLow            one-cycle low after a blocked move
//   SC_FROGREGISTER_Steps_Out                accepted moves, saturating at 255
module sc_frogregister #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int START_COL = 3
) (
  input  logic                 SC_FROGREGISTER_CLOCK_50,
  input  logic                 SC_FROGREGISTER_RESET_InHigh,
  input  logic                 SC_FROGREGISTER_clear_InLow,
  input  logic                 SC_FROGREGISTER_load0_InLow,
  input  logic                 SC_FROGREGISTER_load1_InLow,
  input  logic [1:0]           SC_FROGREGISTER_shiftselection_In,
  output logic [ROWS*COLS-1:0] SC_FROGREGISTER_Matrix_Out,
  output logic                 SC_FROGREGISTER_bottomsidecomparator_OutLow,
  output logic                 SC_FROGREGISTER_topsidecomparator_OutLow,
  output logic                 SC_FROGREGISTER_Arrive_OutLow,
  output logic                 SC_FROGREGISTER_Ack_OutLow,
  output logic                 SC_FROGREGISTER_Reject_OutLow,
  output logic [7:0]           SC_FROGREGISTER_Steps_Out
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [CW-1:0] START     = CW'(START_COL);
  localparam logic [ROWS*COLS-1:0] START_MAP =
    {{(ROWS*COLS-1){1'b0}}, 1'b1} << ((ROWS - 1) * COLS + START_COL);

  logic [RW-1:0]        row, next_row;
  logic [CW-1:0]        col, next_col;
  logic [7:0]           steps, next_steps;
  logic [ROWS*COLS-1:0] next_matrix;
  logic                 next_ack, next_reject, next_arrive;
  logic                 moved;

  logic clear_cmd, up_cmd, down_cmd, left_cmd, right_cmd;

  assign clear_cmd = ~SC_FROGREGISTER_clear_InLow;
  assign up_cmd    = ~SC_FROGREGISTER_load0_InLow;
  assign down_cmd  = ~SC_FROGREGISTER_load1_InLow;
  assign left_cmd  = (SC_FROGREGISTER_shiftselection_In == 2'b01);
  assign right_cmd = (SC_FROGREGISTER_shiftselection_In == 2'b10);

  // Choose exactly one command by priority. A blocked command still wins the
  // arbitration: lower-priority commands are not tried in its place.
  always_comb begin
    next_row    = row;
    next_col    = col;
    next_steps  = steps;
    next_ack    = 1'b1;
    next_reject = 1'b1;
    next_arrive = 1'b1;
    moved       = 1'b0;
    next_matrix = '0;

    if (clear_cmd) begin
      next_row   = LAST_ROW;
      next_col   = START;
      next_steps = 8'd0;
    end else if (up_cmd) begin
      if (row != '0) begin
        next_row = row - RW'(1);
        moved    = 1'b1;
        if (row == RW'(1)) next_arrive = 1'b0;
      end else begin
        next_reject = 1'b0;
      end
    end else if (down_cmd) begin
      if (row != LAST_ROW) begin
        next_row = row + RW'(1);
        moved    = 1'b1;
      end else begin
        next_reject = 1'b0;
      end
    end else if (left_cmd) begin
      if (col != '0) begin
        next_col = col - CW'(1);
        moved    = 1'b1;
      end else begin
        next_reject = 1'b0;
      end
    end else if (right_cmd) begin
      if (col != LAST_COL) begin
        next_col = col + CW'(1);
        moved    = 1'b1;
      end else begin
        next_reject = 1'b0;
      end
    end

    if (moved) begin
      next_ack = 1'b0;
      if (steps != 8'hFF) next_steps = steps + 8'd1;
    end

    // The map is decoded from the next position so it lands in the same edge.
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        next_matrix[r*COLS + c] = (next_row == RW'(r)) && (next_col == CW'(c));
      end
    end
  end

  // Position, map, comparators, pulses and step count all update on one edge.
  always_ff @(posedge SC_FROGREGISTER_CLOCK_50) begin
    if (SC_FROGREGISTER_RESET_InHigh) begin
      row                                         <= LAST_ROW;
      col                                         <= START;
      steps                                       <= 8'd0;
      SC_FROGREGISTER_Matrix_Out                  <= START_MAP;
      SC_FROGREGISTER_bottomsidecomparator_OutLow <= 1'b0;
      SC_FROGREGISTER_topsidecomparator_OutLow    <= 1'b1;
      SC_FROGREGISTER_Arrive_OutLow               <= 1'b1;
      SC_FROGREGISTER_Ack_OutLow                  <= 1'b1;
      SC_FROGREGISTER_Reject_OutLow               <= 1'b1;
    end else begin
      row                                         <= next_row;
      col                                         <= next_col;
      steps                                       <= next_steps;
      SC_FROGREGISTER_Matrix_Out                  <= next_matrix;
      SC_FROGREGISTER_bottomsidecomparator_OutLow <= (next_row != LAST_ROW);
      SC_FROGREGISTER_topsidecomparator_OutLow    <= (next_row != '0);
      SC_FROGREGISTER_Arrive_OutLow               <= next_arrive;
      SC_FROGREGISTER_Ack_OutLow                  <= next_ack;
      SC_FROGREGISTER_Reject_OutLow               <= next_reject;
    end
  end

  assign SC_FROGREGISTER_Steps_Out = steps;

endmodule

// File: tb/tb_sc_frogregister.sv
// tb_sc_frogregister: self-checking bench for sc_frogregister with the default
// 8x8 playfield. A coordinate-level model of the frog is compared against the
// DUT every cycle, and directed scenarios pin key values with literals.
module tb_sc_frogregister;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int START_COL = 3;

  localparam logic [63:0] MAP_7_3 = 64'h0800_0000_0000_0000;
  localparam logic [63:0] MAP_0_3 = 64'h0000_0000_0000_0008;
  localparam logic [63:0] MAP_7_0 = 64'h0100_0000_0000_0000;
  localparam logic [63:0] MAP_4_5 = 64'h0000_0020_0000_0000;
  localparam logic [63:0] MAP_7_7 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_n;
  logic        up_n;
  logic        dn_n;
  logic [1:0]  sh;
  logic [63:0] matrix;
  logic        bottom_n;
  logic        top_n;
  logic        arrive_n;
  logic        ack_n;
  logic        reject_n;
  logic [7:0]  steps;

  int compared   = 0;
  int mismatched = 0;

  // Model state in plain coordinates.
  int   m_row;
  int   m_col;
  int   m_steps;
  logic m_ack;
  logic m_rej;
  logic m_arr;
  logic m_valid = 1'b0;

  sc_frogregister #(.ROWS(ROWS), .COLS(COLS), .START_COL(START_COL)) dut (
    .SC_FROGREGISTER_CLOCK_50                    (clk),
    .SC_FROGREGISTER_RESET_InHigh                (rst),
    .SC_FROGREGISTER_clear_InLow                 (clr_n),
    .SC_FROGREGISTER_load0_InLow                 (up_n),
    .SC_FROGREGISTER_load1_InLow                 (dn_n),
    .SC_FROGREGISTER_shiftselection_In           (sh),
    .SC_FROGREGISTER_Matrix_Out                  (matrix),
    .SC_FROGREGISTER_bottomsidecomparator_OutLow (bottom_n),
    .SC_FROGREGISTER_topsidecomparator_OutLow    (top_n),
    .SC_FROGREGISTER_Arrive_OutLow               (arrive_n),
    .SC_FROGREGISTER_Ack_OutLow                  (ack_n),
    .SC_FROGREGISTER_Reject_OutLow               (reject_n),
    .SC_FROGREGISTER_Steps_Out                   (steps)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic u, input logic d,
                               input logic [1:0] s);
    @(negedge clk);
    rst   = r;
    clr_n = c;
    up_n  = u;
    dn_n  = d;
    sh    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
  endtask

  // Frog model: the game rules in terms of row/column numbers.
  always @(posedge clk) begin
    m_ack <= 1'b1;
    m_rej <= 1'b1;
    m_arr <= 1'b1;
    if (rst) begin
      m_row   <= ROWS - 1;
      m_col   <= START_COL;
      m_steps <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (!clr_n) begin
        m_row   <= ROWS - 1;
        m_col   <= START_COL;
        m_steps <= 0;
      end else if (!up_n) begin
        if (m_row > 0) begin
          m_row   <= m_row - 1;
          m_ack   <= 1'b0;
          m_steps <= (m_steps >= 255) ? 255 : m_steps + 1;
          if (m_row == 1) m_arr <= 1'b0;
        end else m_rej <= 1'b0;
      end else if (!dn_n) begin
        if (m_row < ROWS - 1) begin
          m_row   <= m_row + 1;
          m_ack   <= 1'b0;
          m_steps <= (m_steps >= 255) ? 255 : m_steps + 1;
        end else m_rej <= 1'b0;
      end else if (sh == 2'b01) begin
        if (m_col > 0) begin
          m_col   <= m_col - 1;
          m_ack   <= 1'b0;
          m_steps <= (m_steps >= 255) ? 255 : m_steps + 1;
        end else m_rej <= 1'b0;
      end else if (sh == 2'b10) begin
        if (m_col < COLS - 1) begin
          m_col   <= m_col + 1;
          m_ack   <= 1'b0;
          m_steps <= (m_steps >= 255) ? 255 : m_steps + 1;
        end else m_rej <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, half a period after the edge.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("matrix", matrix, 64'd1 << (m_row * COLS + m_col));
      checkOutput("onehot", 64'($countones(matrix)), 64'd1);
      checkOutput("bottom", {63'd0, bottom_n}, {63'd0, m_row != ROWS - 1});
      checkOutput("top", {63'd0, top_n}, {63'd0, m_row != 0});
      checkOutput("ack", {63'd0, ack_n}, {63'd0, m_ack});
      checkOutput("reject", {63'd0, reject_n}, {63'd0, m_rej});
      checkOutput("arrive", {63'd0, arrive_n}, {63'd0, m_arr});
      checkOutput("steps", {56'd0, steps}, 64'(m_steps));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    clr_n = 1'b1;
    up_n  = 1'b1;
    dn_n  = 1'b1;
    sh    = 2'b00;

    // Reset state, including a command applied under reset.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("rst_matrix", matrix, MAP_7_3);
    checkOutput("rst_bottom", {63'd0, bottom_n}, 64'd0);
    checkOutput("rst_top", {63'd0, top_n}, 64'd1);
    checkOutput("rst_pulses", {61'd0, ack_n, reject_n, arrive_n}, 64'h7);
    checkOutput("rst_steps", {56'd0, steps}, 64'd0);

    // Down from the bottom row is refused.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("down_block_rej", {63'd0, reject_n}, 64'd0);
    checkOutput("down_block_map", matrix, MAP_7_3);
    checkOutput("down_block_steps", {56'd0, steps}, 64'd0);
    idle();
    checkOutput("down_block_rej_end", {63'd0, reject_n}, 64'd1);

    // Seven ups reach the goal row; Arrive only on the last.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
      checkOutput("up_ack", {63'd0, ack_n}, 64'd0);
      checkOutput("up_arrive", {63'd0, arrive_n}, (i == 6) ? 64'd0 : 64'd1);
    end
    checkOutput("goal_map", matrix, MAP_0_3);
    checkOutput("goal_top", {63'd0, top_n}, 64'd0);
    checkOutput("goal_steps", {56'd0, steps}, 64'd7);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    checkOutput("up_block_rej", {63'd0, reject_n}, 64'd0);
    checkOutput("up_block_arrive", {63'd0, arrive_n}, 64'd1);

    // Clear returns to start with no pulses.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    checkOutput("clear_map", matrix, MAP_7_3);
    checkOutput("clear_steps", {56'd0, steps}, 64'd0);
    checkOutput("clear_pulses", {62'd0, ack_n, reject_n}, 64'h3);

    // Left held five cycles: three moves then two refusals.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
      checkOutput("left_ack", {63'd0, ack_n}, (i < 3) ? 64'd0 : 64'd1);
      checkOutput("left_rej", {63'd0, reject_n}, (i < 3) ? 64'd1 : 64'd0);
    end
    checkOutput("left_map", matrix, MAP_7_0);
    checkOutput("left_steps", {56'd0, steps}, 64'd3);

    // Walk to (4,5), then clear+up+right together: clear wins.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    checkOutput("walk_map", matrix, MAP_4_5);
    checkOutput("walk_steps", {56'd0, steps}, 64'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
    checkOutput("prio_map", matrix, MAP_7_3);
    checkOutput("prio_steps", {56'd0, steps}, 64'd0);
    checkOutput("prio_pulses", {62'd0, ack_n, reject_n}, 64'h3);

    // Down beats left when both are asserted.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    checkOutput("down_prio_map", matrix, MAP_7_3);

    // Right edge and hold codes.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    checkOutput("right_map", matrix, MAP_7_7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    checkOutput("right_block_rej", {63'd0, reject_n}, 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
    checkOutput("hold_pulses", {61'd0, ack_n, reject_n, arrive_n}, 64'h7);
    checkOutput("hold_map", matrix, MAP_7_7);

    // 300 alternating up/down moves saturate the step counter.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
      else            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    end
    checkOutput("sat_steps", {56'd0, steps}, 64'd255);
    checkOutput("sat_ack", {63'd0, ack_n}, 64'd0);
    checkOutput("sat_map", matrix, MAP_7_3);

    // Reset with an up command at (2,2).
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
    checkOutput("pre_rst_map", matrix, 64'd1 << 18);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    checkOutput("mid_rst_map", matrix, MAP_7_3);
    checkOutput("mid_rst_pulses", {61'd0, ack_n, reject_n, arrive_n}, 64'h7);
    checkOutput("mid_rst_steps", {56'd0, steps}, 64'd0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
